pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Multicycle instruction-sequencing controller for the MIPS core. Owns the word-addressed PC register,
//  fetches each instruction over a req/ack handshake and decodes its control-flow class. Drives the
//  next-PC mux select (pc_sel) and beq/bne qualifiers, then commits the mux result into the PC.
//  Sits between instruction memory and the datapath; one instruction in flight at a time.
// PARAMETERS
//  START_PC    32'h0  PC value loaded on reset (word address)
//  FETCH_TMO   255    max cycles in FETCH without imem_ack before FAULT; 0 disables watchdog
// PORTS
//  clk         in   1   core clock, rising edge
//  rst_n       in   1   reset, asynchronous, active-low
//  run         in   1   level; 1 = sequence instructions, 0 = stop at next instruction boundary
//  imem_req    out  1   fetch request, held until imem_ack
//  imem_addr   out  32  fetch address (= pc)
//  imem_ack    in   1   fetch complete; imem_rdata valid this cycle
//  imem_rdata  in   32  fetched instruction word
//  instr       out  32  instruction register (IR) to datapath
//  pc          out  32  current PC (word address)
//  pc_sel      out  3   0 seq, 1 beq/bne, 2 j/jal, 3 jr, 4 branch-on-negative
//  beq, bne    out  1   branch qualifiers for pc_sel=1
//  exec_start  out  1   1-cycle pulse: datapath may begin executing instr
//  exec_done   in   1   datapath done; zero/negative/Qs now valid at next-PC mux
//  next_pc     in   32  output of next-PC mux
//  retired     out  1   1-cycle pulse when PC commits
//  halted      out  1   sticky; HALT opcode retired
//  fault       out  1   sticky; fetch watchdog expired
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, pc=START_PC, instr=0, pc_sel=0, beq=bne=0, all pulses/flags 0.
//  States: IDLE, FETCH, DECODE, EXEC, COMMIT, HALT, FAULT.
//   IDLE:   run=1 -> FETCH; else stay.
//   FETCH:  imem_req=1, imem_addr=pc. imem_ack -> latch IR<=imem_rdata, DECODE (ack in first FETCH cycle ok).
//           Watchdog counts FETCH cycles; count reaching FETCH_TMO w/o ack -> FAULT. Cleared on FETCH entry.
//   DECODE: classify IR[31:26] (funct IR[5:0] for R-type); register pc_sel/beq/bne; pulse exec_start; -> EXEC.
//           op 0x04 beq: sel1,beq=1 | 0x05 bne: sel1,bne=1 | 0x02/0x03 j/jal: sel2 | R-type funct 0x08 jr: sel3
//           | 0x01 branch-on-negative: sel4 | 0x3F: HALT (sel0) | all others: sel0.
//   EXEC:   wait exec_done; j/jal leave after 1 cycle regardless. -> COMMIT.
//   COMMIT: pc<=next_pc, retired=1; -> HALT if HALT op (halted=1, pc still advances), else run ? FETCH : IDLE.
//   HALT/FAULT: absorbing; only rst_n exits. fault set on FAULT entry.
//  pc_sel/beq/bne held stable from DECODE through COMMIT; 0 in IDLE/FETCH.
//  Latency per instruction: (fetch wait >=1) + DECODE 1 + EXEC >=1 + COMMIT 1; minimum 4 cycles.
//  run is sampled only in IDLE and COMMIT; deassertion mid-instruction completes it, then IDLE.
//  PC wraps naturally at 32 bits (next_pc from mux, no saturation). exec_done outside EXEC ignored;
//  imem_ack outside FETCH ignored.
// STRUCTURE
//  pc_seq_pkg: state enum, opcode/funct constants, PC_SEL_* localparams (SEQ=0,BR=1,JMP=2,JR=3,BN=4).
//  Sub-module pc_seq_decode: combinational IR -> {pc_sel, beq, bne, is_jump, is_halt}.
//  Top holds FSM, PC/IR registers, watchdog counter.
// TESTING
//  1 Reset, run=1, ack same cycle, nop, exec_done 1 cycle, next_pc=1 -> pc 0->1, retired after 4 cycles.
//  2 IR=beq (0x10xxxxxx), exec_done, next_pc=0x20 -> pc_sel=1,beq=1,bne=0 in EXEC; pc=0x20 post-COMMIT.
//  3 IR=j (0x08000040), exec_done never -> leaves EXEC after 1 cycle, pc_sel=2, pc<=next_pc.
//  4 FETCH_TMO=4, imem_ack held 0 -> fault=1 after 4 FETCH cycles, FAULT held; rst_n low -> IDLE, pc=START_PC.
//  5 IR=0xFC000000 -> HALT after COMMIT, halted=1, further run/ack ignored, imem_req=0.
//  6 rst_n low during EXEC -> async return to IDLE, pc=START_PC, exec_start/retired 0; run=0 in EXEC -> IDLE.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared constants and types for the multicycle PC sequencer: FSM states,
// opcode/funct values, next-PC mux selects and the decode result bundle.
package pc_seq_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_COMMIT = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;
  localparam logic [2:0] ST_FAULT  = 3'd6;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BN    = 6'h01;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_HALT  = 6'h3F;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [2:0] PC_SEL_SEQ = 3'd0;
  localparam logic [2:0] PC_SEL_BR  = 3'd1;
  localparam logic [2:0] PC_SEL_JMP = 3'd2;
  localparam logic [2:0] PC_SEL_JR  = 3'd3;
  localparam logic [2:0] PC_SEL_BN  = 3'd4;

  typedef struct packed {
    logic [2:0] pc_sel;
    logic       beq;
    logic       bne;
    logic       is_jump;
    logic       is_halt;
  } dec_t;

endpackage

// File: rtl/pc_seq_decode.sv
// Combinational control-flow classifier: instruction word -> next-PC select,
// branch qualifiers and jump/halt flags.
module pc_seq_decode
  import pc_seq_pkg::*;
(
  input  logic [31:0] ir,
  output dec_t        dec
);

  always_comb begin
    // NOTE: default every field first so no path through the case infers a latch.
    dec = '0;
    unique case (ir[31:26])
      OP_BEQ:       begin dec.pc_sel = PC_SEL_BR; dec.beq = 1'b1; end
      OP_BNE:       begin dec.pc_sel = PC_SEL_BR; dec.bne = 1'b1; end
      OP_J, OP_JAL: begin dec.pc_sel = PC_SEL_JMP; dec.is_jump = 1'b1; end
      OP_RTYPE:     dec.pc_sel = (ir[5:0] == FN_JR) ? PC_SEL_JR : PC_SEL_SEQ;
      OP_BN:        dec.pc_sel = PC_SEL_BN;
      OP_HALT:      dec.is_halt = 1'b1;
      default:      dec.pc_sel = PC_SEL_SEQ;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multicycle instruction sequencer: owns PC and IR, fetches over req/ack,
// drives next-PC mux controls and commits the mux result, one instruction at a time.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] START_PC  = 32'h0,
  parameter int          FETCH_TMO = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [2:0]  pc_sel,
  output logic        beq,
  output logic        bne,
  output logic        exec_start,
  input  logic        exec_done,
  input  logic [31:0] next_pc,
  output logic        retired,
  output logic        halted,
  output logic        fault
);

  localparam int              CW       = (FETCH_TMO > 1) ? $clog2(FETCH_TMO + 1) : 1;
  localparam logic [CW-1:0]   TMO_LAST = CW'(FETCH_TMO - 1);

  logic [2:0]    state;
  logic [CW-1:0] wdog;
  logic          is_jump_q;
  logic          is_halt_q;
  dec_t          dec;

  pc_seq_decode u_decode (
    .ir  (instr),
    .dec (dec)
  );

  assign imem_req  = (state == ST_FETCH);
  assign imem_addr = pc;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pc         <= START_PC;
      instr      <= '0;
      pc_sel     <= PC_SEL_SEQ;
      beq        <= 1'b0;
      bne        <= 1'b0;
      is_jump_q  <= 1'b0;
      is_halt_q  <= 1'b0;
      exec_start <= 1'b0;
      retired    <= 1'b0;
      halted     <= 1'b0;
      fault      <= 1'b0;
      wdog       <= '0;
    end else begin
      exec_start <= 1'b0;
      retired    <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (run) begin
            state <= ST_FETCH;
            wdog  <= '0;
          end
        end
        ST_FETCH: begin
          // An ack on the final watchdog cycle still wins over the timeout.
          if (imem_ack) begin
            instr <= imem_rdata;
            state <= ST_DECODE;
          end else if (FETCH_TMO != 0 && wdog == TMO_LAST) begin
            state <= ST_FAULT;
            fault <= 1'b1;
          end else begin
            wdog <= wdog + CW'(1);
          end
        end
        ST_DECODE: begin
          pc_sel     <= dec.pc_sel;
          beq        <= dec.beq;
          bne        <= dec.bne;
          is_jump_q  <= dec.is_jump;
          is_halt_q  <= dec.is_halt;
          exec_start <= 1'b1;
          state      <= ST_EXEC;
        end
        ST_EXEC: begin
          if (exec_done || is_jump_q) state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          pc      <= next_pc;
          retired <= 1'b1;
          pc_sel  <= PC_SEL_SEQ;
          beq     <= 1'b0;
          bne     <= 1'b0;
          if (is_halt_q) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else if (run) begin
            state <= ST_FETCH;
            wdog  <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_HALT:  state <= ST_HALT;
        ST_FAULT: state <= ST_FAULT;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: the bench plays instruction memory and
// datapath, and a per-cycle compare process checks outputs against a transaction model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        exec_done = 1'b0;
  logic [31:0] next_pc = '0;
  logic        imem_req, beq, bne, exec_start, retired, halted, fault;
  logic [31:0] imem_addr, instr, pc;
  logic [2:0]  pc_sel;

  always #5 clk = ~clk;

  pc_sequencer #(.START_PC(32'h0), .FETCH_TMO(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .pc(pc), .pc_sel(pc_sel), .beq(beq), .bne(bne),
    .exec_start(exec_start), .exec_done(exec_done), .next_pc(next_pc),
    .retired(retired), .halted(halted), .fault(fault)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural model: committed PC, IR, sticky flags, pending retire pulse.
  logic [31:0] m_pc = '0, m_ir = '0;
  bit          m_halt, m_fault, m_ret;
  // Expected per-cycle control outputs for the cycle in progress.
  bit          e_req, e_bq, e_bn, e_xs, e_ret, chk_en;
  logic [2:0]  e_sel;
  logic [2:0]  sel_seen;
  logic        bq_seen, bn_seen;

  always @(negedge clk) begin
    if (chk_en) begin
      check("imem_req",   32'(imem_req),   32'(e_req));
      check("imem_addr",  imem_addr,       m_pc);
      check("pc",         pc,              m_pc);
      check("instr",      instr,           m_ir);
      check("pc_sel",     32'(pc_sel),     32'(e_sel));
      check("beq",        32'(beq),        32'(e_bq));
      check("bne",        32'(bne),        32'(e_bn));
      check("exec_start", 32'(exec_start), 32'(e_xs));
      check("retired",    32'(retired),    32'(e_ret));
      check("halted",     32'(halted),     32'(m_halt));
      check("fault",      32'(fault),      32'(m_fault));
    end
    if (exec_start) begin
      sel_seen = pc_sel;
      bq_seen  = beq;
      bn_seen  = bne;
    end
  end

  function automatic bit rb();
    return ($urandom() & 32'd1) != 32'd0;
  endfunction

  function automatic void klass(input logic [31:0] w, output logic [2:0] s,
                                output bit bq, output bit bn, output bit jmp, output bit hlt);
    s = 3'd0; bq = 1'b0; bn = 1'b0; jmp = 1'b0; hlt = 1'b0;
    case (w[31:26])
      6'h04: begin s = 3'd1; bq = 1'b1; end
      6'h05: begin s = 3'd1; bn = 1'b1; end
      6'h02, 6'h03: begin s = 3'd2; jmp = 1'b1; end
      6'h00: s = (w[5:0] == 6'h08) ? 3'd3 : 3'd0;
      6'h01: s = 3'd4;
      6'h3F: hlt = 1'b1;
      default: s = 3'd0;
    endcase
  endfunction

  function automatic logic [31:0] gen_word();
    logic [31:0] w;
    logic [5:0]  op;
    w = $urandom();
    case ($urandom_range(0, 6))
      0: op = 6'h00;
      1: op = 6'h01;
      2: op = 6'h02;
      3: op = 6'h03;
      4: op = 6'h04;
      5: op = 6'h05;
      default: begin
        op = 6'($urandom());
        if (op == 6'h3F) op = 6'h2B;
      end
    endcase
    w[31:26] = op;
    if (op == 6'h00 && rb()) w[5:0] = 6'h08;
    return w;
  endfunction

  // One clock cycle: expectations for the cycle in progress, inputs sampled at its end.
  task automatic cyc(input bit req, input logic [2:0] sel, input bit bq, input bit bn, input bit xs,
                     input bit ack, input logic [31:0] rd, input bit done, input bit rn,
                     input logic [31:0] npc);
    e_req = req; e_sel = sel; e_bq = bq; e_bn = bn; e_xs = xs;
    e_ret = m_ret; m_ret = 1'b0;
    imem_ack = ack; imem_rdata = rd; exec_done = done; run = rn; next_pc = npc;
    @(posedge clk); #1;
  endtask

  task automatic idle_cyc(input bit rn);
    cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, rb(), $urandom(), rb(), rn, $urandom());
  endtask

  // Full instruction from its first FETCH cycle through COMMIT. a = FETCH cycles
  // before ack, e = EXEC cycles before exec_done (non-jumps only).
  task automatic do_instr(input logic [31:0] w, input int a, input int e, input bit done_never,
                          input logic [31:0] npc, input bit rn_after);
    logic [2:0] s;
    bit bq, bn, jmp, hlt;
    klass(w, s, bq, bn, jmp, hlt);
    for (int k = 0; k <= a; k++)
      cyc(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, k == a, (k == a) ? w : $urandom(), rb(), rb(), $urandom());
    m_ir = w;
    cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, rb(), $urandom(), rb(), rb(), $urandom());
    if (jmp)
      cyc(1'b0, s, bq, bn, 1'b1, rb(), $urandom(), done_never ? 1'b0 : rb(), rb(), $urandom());
    else
      for (int j = 0; j <= e; j++)
        cyc(1'b0, s, bq, bn, j == 0, rb(), $urandom(), j == e, rb(), $urandom());
    cyc(1'b0, s, bq, bn, 1'b0, rb(), $urandom(), rb(), rn_after, npc);
    m_pc = npc;
    m_ret = 1'b1;
    if (hlt) m_halt = 1'b1;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    run = 1'b0; imem_ack = 1'b0; exec_done = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_pc",         pc,               32'h0);
    check("rst_instr",      instr,            32'h0);
    check("rst_pc_sel",     32'(pc_sel),      32'h0);
    check("rst_beq_bne",    32'({beq, bne}),  32'h0);
    check("rst_imem_req",   32'(imem_req),    32'h0);
    check("rst_exec_start", 32'(exec_start),  32'h0);
    check("rst_retired",    32'(retired),     32'h0);
    check("rst_halted",     32'(halted),      32'h0);
    check("rst_fault",      32'(fault),       32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    m_pc = '0; m_ir = '0; m_halt = 1'b0; m_fault = 1'b0; m_ret = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    do_reset();

    // Minimal nop: ack in first FETCH cycle, exec_done immediately.
    idle_cyc(1'b1);
    do_instr(32'h0000_0000, 0, 0, 1'b0, 32'h1, 1'b1);
    check("t1_pc", pc, 32'h1);
    check("t1_retired", 32'(retired), 32'h1);

    // beq with delayed ack and exec.
    do_instr(32'h1022_1234, 1, 2, 1'b0, 32'h20, 1'b1);
    check("t2_sel", 32'(sel_seen), 32'h1);
    check("t2_beq_bne", 32'({bq_seen, bn_seen}), 32'h2);
    check("t2_pc", pc, 32'h20);

    // j with exec_done never asserted.
    do_instr(32'h0800_0040, 2, 0, 1'b1, 32'h40, 1'b1);
    check("t3_sel", 32'(sel_seen), 32'h2);
    check("t3_pc", pc, 32'h40);

    // Watchdog: four FETCH cycles with no ack, then FAULT absorbs.
    for (int k = 0; k < 4; k++)
      cyc(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, $urandom(), rb(), rb(), $urandom());
    m_fault = 1'b1;
    repeat (3) cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, $urandom(), 1'b1, 1'b1, $urandom());
    check("t4_fault", 32'(fault), 32'h1);
    check("t4_pc_held", pc, 32'h40);
    do_reset();

    // HALT retires, advances PC, then ignores run/ack.
    idle_cyc(1'b1);
    do_instr(32'hFC00_0000, 1, 1, 1'b0, 32'h77, 1'b1);
    repeat (4) cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, $urandom(), 1'b1, 1'b1, $urandom());
    check("t5_halted", 32'(halted), 32'h1);
    check("t5_pc", pc, 32'h77);
    check("t5_req", 32'(imem_req), 32'h0);
    do_reset();

    // Randomized traffic, including run drops at instruction boundaries.
    idle_cyc(1'b1);
    for (int i = 0; i < 200; i++) begin
      bit rn;
      rn = ($urandom_range(0, 3) != 0);
      do_instr(gen_word(), $urandom_range(0, 3), $urandom_range(0, 3), rb(), $urandom(), rn);
      if (!rn) begin
        repeat ($urandom_range(0, 2)) idle_cyc(1'b0);
        idle_cyc(1'b1);
      end
    end

    // Async reset while in EXEC.
    do_instr(32'h0000_0020, 0, 0, 1'b0, 32'h1234, 1'b1);
    cyc(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0020, 1'b0, 1'b1, $urandom());
    m_ir = 32'h0000_0020;
    cyc(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, $urandom(), 1'b0, 1'b1, $urandom());
    chk_en = 1'b0;
    check("t6_exec_start", 32'(exec_start), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_pc", pc, 32'h0);
    check("t6_exec_start_rst", 32'(exec_start), 32'h0);
    check("t6_retired_rst", 32'(retired), 32'h0);
    check("t6_instr_rst", instr, 32'h0);
    do_reset();

    // run dropped mid-instruction: finishes, then parks in IDLE.
    idle_cyc(1'b1);
    do_instr(32'h0000_0020, 0, 3, 1'b0, 32'h55, 1'b0);
    idle_cyc(1'b0);
    idle_cyc(1'b0);
    check("t6_idle_pc", pc, 32'h55);
    check("t6_idle_req", 32'(imem_req), 32'h0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
